// File: rtl/spi_peripheral.sv
// spi_peripheral: write-only SPI mode-0 target holding the five PWM
// configuration registers. Pins are synchronised into clk, frames are
// shifted in while nCS is low and validated on the nCS rising edge.
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Bit counter saturates one past a full frame so over-long frames stay visible.
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;
  logic [15:0]            r_shift;
  logic [15:0]            w_shift_nxt;
  logic [4:0]             r_cnt;
  logic [4:0]             w_cnt_nxt;
  logic                   w_commit;
  logic [7:0]             r_reg_out_lo;
  logic [7:0]             r_reg_out_hi;
  logic [7:0]             r_reg_pwm_lo;
  logic [7:0]             r_reg_pwm_hi;
  logic [7:0]             r_reg_duty;
  logic                   r_txn_done;

  logic       w_sclk_cur;
  logic       w_ncs_cur;
  logic       w_copi_cur;
  logic       w_sclk_rise;
  logic       w_ncs_fall;
  logic       w_ncs_rise;
  logic [6:0] w_addr;
  logic [7:0] w_data;

  assign w_sclk_cur  = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_cur   = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi_cur  = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_cur & ~r_sclk_prev;
  assign w_ncs_fall  = ~w_ncs_cur & r_ncs_prev;
  assign w_ncs_rise  = w_ncs_cur & ~r_ncs_prev;
  assign w_addr      = r_shift[14:8];
  assign w_data      = r_shift[7:0];

  // Synchronise the three SPI pins and keep one delayed copy of SCLK/nCS for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_sclk_prev <= w_sclk_cur;
      r_ncs_prev  <= w_ncs_cur;
    end
  end

  // FSM state, shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= 16'h0000;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, shift/count update and frame validation.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 5'd0;
        if (w_ncs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = 16'h0000;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_sclk_rise && !w_ncs_cur) begin
          w_shift_nxt = {r_shift[14:0], w_copi_cur};
          if (r_cnt != CNT_SAT) begin
            w_cnt_nxt = r_cnt + 5'd1;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        w_commit    = (r_cnt == CNT_FULL) && r_shift[15] && (w_addr <= MAX_ADDR);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Configuration registers and the one-cycle commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_out_lo <= 8'h00;
      r_reg_out_hi <= 8'h00;
      r_reg_pwm_lo <= 8'h00;
      r_reg_pwm_hi <= 8'h00;
      r_reg_duty   <= 8'h00;
      r_txn_done   <= 1'b0;
    end else begin
      r_txn_done <= w_commit;
      if (w_commit) begin
        case (w_addr)
          7'h00:   r_reg_out_lo <= w_data;
          7'h01:   r_reg_out_hi <= w_data;
          7'h02:   r_reg_pwm_lo <= w_data;
          7'h03:   r_reg_pwm_hi <= w_data;
          7'h04:   r_reg_duty   <= w_data;
          default: r_reg_duty   <= r_reg_duty;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_reg_out_lo;
  assign en_reg_out_15_8 = r_reg_out_hi;
  assign en_reg_pwm_7_0  = r_reg_pwm_lo;
  assign en_reg_pwm_15_8 = r_reg_pwm_hi;
  assign pwm_duty_cycle  = r_reg_duty;
  assign txn_done        = r_txn_done;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: drives mode-0 frames at SCLK = clk/8
// and checks register contents and txn_done timing against fixed values.
module tb_spi_peripheral;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       txn_done;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .ncs             (ncs),
    .copi            (copi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .txn_done        (txn_done)
  );

  // 10 MHz clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Count every cycle in which txn_done is high.
  always @(negedge clk) begin
    if (txn_done === 1'b1) pulses++;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_start();
    ncs = 1'b0;
    wait_clks(4);
  endtask

  task automatic spi_bits(input logic [16:0] v, input int n);
    logic [16:0] vv;
    vv = v;
    for (int i = n - 1; i >= 0; i--) begin
      copi = vv[i];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
  endtask

  // Raise nCS and check txn_done on each of the next five edges: only edge 4 may pulse.
  task automatic spi_end(input logic exp_pulse, input string tag);
    wait_clks(4);
    ncs = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      wait_clks(1);
      if (e == 4) chk({31'd0, txn_done}, {31'd0, exp_pulse}, {tag, "_txn_edge4"});
      else        chk({31'd0, txn_done}, 32'd0, {tag, "_txn_quiet"});
    end
    wait_clks(3);
  endtask

  task automatic frame(input logic [16:0] v, input int n, input logic exp_pulse, input string tag);
    spi_start();
    spi_bits(v, n);
    spi_end(exp_pulse, tag);
  endtask

  task automatic chk_regs(input logic [39:0] exp, input string tag);
    chk({24'd0, en_reg_out_7_0},  {24'd0, exp[39:32]}, {tag, "_reg0"});
    chk({24'd0, en_reg_out_15_8}, {24'd0, exp[31:24]}, {tag, "_reg1"});
    chk({24'd0, en_reg_pwm_7_0},  {24'd0, exp[23:16]}, {tag, "_reg2"});
    chk({24'd0, en_reg_pwm_15_8}, {24'd0, exp[15:8]},  {tag, "_reg3"});
    chk({24'd0, pwm_duty_cycle},  {24'd0, exp[7:0]},   {tag, "_reg4"});
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    ncs   = 1'b1;
    copi  = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);

    // Reset defaults
    chk_regs(40'h00_00_00_00_00, "reset");
    chk({31'd0, txn_done}, 32'd0, "reset_txn");

    // First write to address 0
    frame(17'h080F0, 16, 1'b1, "wr0");
    chk_regs(40'hF0_00_00_00_00, "wr0");

    // Remaining registers
    frame(17'h08155, 16, 1'b1, "wr1");
    frame(17'h082AA, 16, 1'b1, "wr2");
    frame(17'h08301, 16, 1'b1, "wr3");
    frame(17'h08480, 16, 1'b1, "wr4");
    chk_regs(40'hF0_55_AA_01_80, "wr_all");
    chk(pulses, 32'd5, "pulse_count_5");

    // Read frame and out-of-range address are ignored
    frame(17'h00012, 16, 1'b0, "read");
    frame(17'h085FF, 16, 1'b0, "badaddr");
    chk_regs(40'hF0_55_AA_01_80, "ignored");

    // 15-bit and 17-bit frames are discarded
    frame(17'h04078, 15, 1'b0, "short15");
    frame(17'h101E1, 17, 1'b0, "long17");
    chk_regs(40'hF0_55_AA_01_80, "badlen");
    frame(17'h080C3, 16, 1'b1, "wrC3");
    chk({24'd0, en_reg_out_7_0}, 32'h0000_00C3, "wrC3_reg0");
    chk(pulses, 32'd6, "pulse_count_6");

    // Reset in the middle of a frame; finish it after release with nCS still low
    spi_start();
    spi_bits(17'h00084, 8);
    rst_n = 1'b0;
    #1;
    chk_regs(40'h00_00_00_00_00, "midrst_clear");
    wait_clks(2);
    rst_n = 1'b1;
    spi_bits(17'h000FF, 8);
    spi_end(1'b0, "midrst");
    chk({24'd0, pwm_duty_cycle}, 32'd0, "midrst_duty");

    // A clean frame afterwards works
    frame(17'h084FF, 16, 1'b1, "duty");
    chk_regs(40'h00_00_00_00_FF, "duty");
    chk(pulses, 32'd7, "pulse_count_7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
